dds_seq_ctrl: RTL
=================

Name: dds_seq_ctrl

Overview:
- Sequencer for one DDS burst in the NMR excitation chain: LOAD, then SETTLE, then RUN, optionally repeated, then DONE.
- Drives the state_start/state_over enables consumed by the 8-bit DDS window timer.
- Issues the DDS load strobe.
- Keeps its own 8-bit phase timer so it can end each phase at a programmed cycle count.
- Sits between the pulse-sequence master (start/abort/config) and the DDS core plus its timer.

Parameters:
- TW, 8, phase timer and duration-config width.
- RW, 4, repetition-count width.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  level; forces return to IDLE.
- cfg_settle  in  TW  SETTLE duration in cycles; 0 is treated as 1.
- cfg_run  in  TW  RUN duration in cycles; 0 is treated as 1.
- cfg_rep  in  RW  extra repetitions after the first burst (DDS_SEQ_REPEAT_EN only).
- dds_load  out  1  one-cycle strobe; DDS latches its frequency/phase word.
- state_start  out  1  high in SETTLE and RUN.
- state_over  out  1  high in RUN only (timer enabled = state_start & state_over).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an abort ends a sequence.
- rep_left  out  RW  remaining repetitions; 0 when the macro is absent.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs 0; phase timer 0; latched configuration 0.
  - Reset has priority over every other input, including mid-sequence; no done or aborted pulse is produced.
- States: IDLE, LOAD, SETTLE, RUN, DONE. All outputs are registered and decoded from the next-state value, so each output is valid in the same cycle its state is occupied.
- IDLE:
  - start=1 and abort=0 → latch cfg_settle, cfg_run and cfg_rep; go to LOAD.
  - Start-to-dds_load latency: 1 cycle.
  - Config inputs are don't-care after latching; mid-sequence changes have no effect.
- LOAD: exactly 1 cycle; dds_load=1; then SETTLE.
- SETTLE:
  - Phase timer starts at 0 and increments each cycle.
  - Exits when timer equals max(cfg_settle,1)-1, so the phase lasts max(cfg_settle,1) cycles.
  - Timer clears to 0 on exit; next state is RUN.
- RUN: same timing rule using cfg_run. On exit:
  - rep_left != 0 → decrement rep_left, go to LOAD.
  - otherwise → DONE.
- DONE: 1 cycle; done=1; busy=1; then IDLE. A start arriving during DONE is ignored.
- Abort:
  - In any state except IDLE, abort=1 → IDLE on the next edge; aborted=1 for that 1 cycle; done is not asserted.
  - Abort during DONE: done is already asserted in that cycle; aborted is not raised.
  - Abort in IDLE is ignored and takes priority over a same-cycle start (stay in IDLE).
- Arithmetic: the timer is TW bits unsigned and can never wrap, because the exit compare fires at the latched value minus 1, which is at most 2^TW-2.
- Totals:
  - Cycles from dds_load to done = (1+S+R)·(reps+1), where S=max(cfg_settle,1) and R=max(cfg_run,1).
  - Cycles from the start edge to done is one more.

Optional Feature:
- DDS_SEQ_REPEAT_EN
  - Defined: cfg_rep is latched and rep_left works as described above.
  - Undefined: cfg_rep is ignored, rep_left is tied to 0 and RUN always exits to DONE (single burst).

Test Plan:
- Reset mid-RUN (rst_n=0 for 1 cycle) → next cycle all outputs 0, state IDLE, no done or aborted pulse.
- cfg_settle=3, cfg_run=5, cfg_rep=0; start pulse at cycle 0 →
  - dds_load at cycle 1;
  - state_start cycles 2–9;
  - state_over cycles 5–9;
  - done at cycle 10;
  - busy cycles 1–10.
- cfg_settle=0, cfg_run=0 → SETTLE and RUN each last 1 cycle; done 4 cycles after start.
- DDS_SEQ_REPEAT_EN defined, cfg_rep=2, settle=2, run=2 → 3 dds_load pulses spaced 5 cycles apart; rep_left goes 2→1→0; done once, at cycle 16.
- Abort asserted in the 2nd cycle of SETTLE → next cycle IDLE, aborted=1, state_start=0, no done; a new start afterwards runs normally.
- start and abort together in IDLE → remains IDLE, no dds_load; start during DONE → ignored.

Source files
------------

// File: rtl/dds_seq_ctrl_if.sv
// Control/status bundle between the pulse-sequence master and the DDS burst sequencer.
// The master modport drives requests and configuration.
// The slave modport (dds_seq_ctrl) drives the strobes, window enables and status.
interface dds_seq_ctrl_if #(
  parameter int unsigned TW = 8,
  parameter int unsigned RW = 4
);
  logic          start;
  logic          abort;
  logic [TW-1:0] cfg_settle;
  logic [TW-1:0] cfg_run;
  logic [RW-1:0] cfg_rep;
  logic          dds_load;
  logic          state_start;
  logic          state_over;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [RW-1:0] rep_left;

  modport master (
    output start, abort, cfg_settle, cfg_run, cfg_rep,
    input  dds_load, state_start, state_over, busy, done, aborted, rep_left
  );

  modport slave (
    input  start, abort, cfg_settle, cfg_run, cfg_rep,
    output dds_load, state_start, state_over, busy, done, aborted, rep_left
  );
endinterface

// File: rtl/dds_seq_ctrl.sv
// DDS burst sequencer: LOAD -> SETTLE -> RUN (optionally repeated) -> DONE.
// Drives the DDS load strobe and the state_start/state_over window-timer enables.
// Optional macro DDS_SEQ_REPEAT_EN enables cfg_rep / rep_left repetition support.
// Without the macro, cfg_rep is ignored, rep_left is 0 and RUN always ends in DONE.
module dds_seq_ctrl #(
  parameter int unsigned TW = 8,
  parameter int unsigned RW = 4
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  dds_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] settle_q, run_q;
  logic [TW-1:0] lim, lim_m1;
  logic          phase_end;
  logic          abort_evt;
  logic          cfg_take;
`ifdef DDS_SEQ_REPEAT_EN
  logic [RW-1:0] rep_q, rep_d;
`endif

  // Next-state, phase-timer and repetition-count logic.
  // A programmed duration of 0 is folded to 1 here, so the exit compare never needs the timer to wrap.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
`ifdef DDS_SEQ_REPEAT_EN
    rep_d     = rep_q;
`endif
    lim       = (state_q == S_RUN) ? run_q : settle_q;
    lim_m1    = (lim == '0) ? '0 : lim - TW'(1);
    phase_end = (timer_q == lim_m1);
    abort_evt = bus.abort && (state_q inside {S_LOAD, S_SETTLE, S_RUN});
    cfg_take  = (state_q == S_IDLE) && bus.start && !bus.abort;

    case (state_q)
      S_IDLE:   if (cfg_take) state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: begin
        if (phase_end) state_d = S_RUN;
        else           timer_d = timer_q + TW'(1);
      end
      S_RUN: begin
        if (phase_end) begin
`ifdef DDS_SEQ_REPEAT_EN
          if (rep_q != '0) begin
            rep_d   = rep_q - RW'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort_evt) begin
      state_d = S_IDLE;
      timer_d = '0;
`ifdef DDS_SEQ_REPEAT_EN
      rep_d   = '0;
`endif
    end
  end

  // State, timer and latched configuration registers.
  // The outputs are decoded from state_d, so each one is valid in the same cycle as its state.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      settle_q        <= '0;
      run_q           <= '0;
      bus.dds_load    <= 1'b0;
      bus.state_start <= 1'b0;
      bus.state_over  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.aborted     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      if (cfg_take) begin
        settle_q <= bus.cfg_settle;
        run_q    <= bus.cfg_run;
      end
      bus.dds_load    <= (state_d == S_LOAD);
      bus.state_start <= (state_d == S_SETTLE) || (state_d == S_RUN);
      bus.state_over  <= (state_d == S_RUN);
      bus.busy        <= (state_d != S_IDLE);
      bus.done        <= (state_d == S_DONE);
      bus.aborted     <= abort_evt;
    end
  end

`ifdef DDS_SEQ_REPEAT_EN
  // Repetition counter: loaded with cfg_rep on start and decremented at each RUN exit that loops back to LOAD.
  always_ff @(posedge clk_sys) begin
    if (!rst_n)        rep_q <= '0;
    else if (cfg_take) rep_q <= bus.cfg_rep;
    else               rep_q <= rep_d;
  end

  assign bus.rep_left = rep_q;
`else
  assign bus.rep_left = '0;
`endif

endmodule
